// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Receive-side serial front end. Recovers 8-bit characters from the
//   asynchronous rxd line by oversampling at 16 ticks per bit. Parity and
//   MSB-first bit order are optional. Each character and its error flags are
//   handed to the downstream parser through a one-entry valid/ready buffer.
//
//   Optional build macro: RX_MAJORITY_VOTE_EN
//     When defined, every bit value is the 2-of-3 majority of the line at tick
//     counts 7, 8 and 9. The decision is made at tick count 9, and the counter
//     phase is shifted so that the decision lands on the same clock as the
//     single-sample build.
//
//   Parameters
//     DIV_W        width of the baud divider input
//     SYNC_STAGES  number of flops in the rxd synchronizer (minimum 2)
//
//   Ports
//     i_clk         system clock
//     i_rst_n       synchronous active-low reset
//     i_rxd         asynchronous serial input, idles high
//     i_baud_div    oversample tick period minus 1
//     i_parity_en   a parity bit follows the data bits
//     i_parity_odd  1 = odd parity, 0 = even parity
//     i_msb_first   first data bit received is bit 7
//     o_rx_data     received character
//     o_rx_valid    o_rx_data and the flags are valid
//     i_rx_ready    downstream accepts the character
//     o_parity_err  parity mismatch for the held character
//     o_frame_err   stop bit sampled low for the held character
//     o_overrun     one-clock pulse when a completed character is dropped
//     o_busy        receiver FSM is not idle
module uart_rx_deserializer #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rxd,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_parity_en,
  input  logic             i_parity_odd,
  input  logic             i_msb_first,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

`ifdef RX_MAJORITY_VOTE_EN
  // Starting the start-bit count at 2 makes the 8th tick read 9, so the
  // voted decision happens on the same clock as the single-sample build.
  // After the start decision the counter simply keeps counting, giving a
  // decision every 16 ticks at count 9.
  localparam logic [3:0] START_INIT   = 4'd2;
  localparam logic [3:0] START_PT     = 4'd9;
  localparam logic [3:0] START_RELOAD = 4'd10;
  localparam logic [3:0] BIT_PT       = 4'd9;
`else
  localparam logic [3:0] START_INIT   = 4'd0;
  localparam logic [3:0] START_PT     = 4'd7;
  localparam logic [3:0] START_RELOAD = 4'd0;
  localparam logic [3:0] BIT_PT       = 4'd15;
`endif

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [3:0]             r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par_err;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_msb_first;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_rxs;
  logic                   w_tick;
  logic                   w_bit;
  logic                   w_start_pt;
  logic                   w_bit_pt;
  logic                   w_start_det;
  logic                   w_complete;
  logic                   w_frame_err_next;

  // Synchronizer presets to the idle level so reset never fakes a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_rxs  = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_state != S_IDLE) && (r_div_cnt == '0);

`ifdef RX_MAJORITY_VOTE_EN
  // Two-entry history of the line at the previous two ticks; at the decision
  // tick it holds the samples from counts 7 and 8.
  logic [1:0] r_hist;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hist <= 2'b11;
    end else if (w_tick) begin
      r_hist <= {r_hist[0], w_rxs};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  assign w_start_pt = w_tick && (r_tick_cnt == START_PT);
  assign w_bit_pt   = w_tick && (r_tick_cnt == BIT_PT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the strobes that tell the datapath when a frame
  // starts and when a character is complete.
  always_comb begin
    w_state_next     = r_state;
    w_start_det      = 1'b0;
    w_complete       = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rxs_prev && !w_rxs) begin
          w_start_det  = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_start_pt) begin
          w_state_next = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_pt && (r_bit_cnt == 3'd7)) begin
          w_state_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_pt) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_pt) begin
          w_complete       = 1'b1;
          w_frame_err_next = ~w_bit;
          w_state_next     = w_bit ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Divider, tick/bit counters and the shift register. Line-format inputs are
  // captured at start detect so mid-frame changes cannot corrupt a character.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div_cnt   <= '0;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_msb_first <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_div_cnt   <= i_baud_div;
        r_tick_cnt  <= START_INIT;
        r_bit_cnt   <= '0;
        r_par_err   <= 1'b0;
        r_par_en    <= i_parity_en;
        r_par_odd   <= i_parity_odd;
        r_msb_first <= i_msb_first;
      end else if (r_state != S_IDLE) begin
        if (w_tick) begin
          r_div_cnt  <= i_baud_div;
          r_tick_cnt <= (r_state == S_START && r_tick_cnt == START_PT) ?
                        START_RELOAD : r_tick_cnt + 4'd1;
        end else begin
          r_div_cnt <= r_div_cnt - DIV_W'(1);
        end
      end
      if (r_state == S_DATA && w_bit_pt) begin
        r_shift   <= r_msb_first ? {r_shift[6:0], w_bit} : {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (r_state == S_PARITY && w_bit_pt) begin
        r_par_err <= ((^r_shift) ^ w_bit) != r_par_odd;
      end
    end
  end

  // One-entry output buffer. A completing character may replace the held one
  // only if that one is being accepted in the same cycle; otherwise the new
  // character is dropped and overrun pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete && (!r_rx_valid || i_rx_ready)) begin
        r_rx_data    <= r_shift;
        r_parity_err <= r_par_err;
        r_frame_err  <= w_frame_err_next;
        r_rx_valid   <= 1'b1;
      end else begin
        if (r_rx_valid && i_rx_ready) begin
          r_rx_valid <= 1'b0;
        end
        if (w_complete) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed bench for uart_rx_deserializer. Baud divider 3 gives a tick
//   every 4 clocks, so one bit lasts 64 clocks. Frames are driven on falling
//   clock edges and outputs are compared on falling edges.
module tb_uart_rx_deserializer;

  localparam int DIV_W        = 16;
  localparam int CLKS_PER_BIT = 64;

  logic             clock = 1'b0;
  logic             resetN;
  logic             rxd;
  logic [DIV_W-1:0] baudDiv;
  logic             parityEn;
  logic             parityOdd;
  logic             msbFirst;
  logic [7:0]       rxData;
  logic             rxValid;
  logic             rxReady;
  logic             parityErr;
  logic             frameErr;
  logic             overrun;
  logic             busy;

  int   checks         = 0;
  int   errors         = 0;
  int   overrunCount   = 0;
  int   validRiseCount = 0;
  logic prevValid      = 1'b0;
  int   baseRise;
  int   baseOverrun;

  uart_rx_deserializer #(
    .DIV_W      (DIV_W),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk       (clock),
    .i_rst_n     (resetN),
    .i_rxd       (rxd),
    .i_baud_div  (baudDiv),
    .i_parity_en (parityEn),
    .i_parity_odd(parityOdd),
    .i_msb_first (msbFirst),
    .o_rx_data   (rxData),
    .o_rx_valid  (rxValid),
    .i_rx_ready  (rxReady),
    .o_parity_err(parityErr),
    .o_frame_err (frameErr),
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  // Counts overrun clocks and rx_valid rising edges so pulses between the
  // directed check points are not missed.
  always @(negedge clock) begin
    if (overrun) overrunCount++;
    if (rxValid && !prevValid) validRiseCount++;
    prevValid = rxValid;
  end

  // Keeps a broken design from hanging the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one frame. readyAt pulses rxReady for one clock at that clock
  // index of the frame; resetAt pulses resetN for one clock and then holds
  // the line idle for the remainder of the frame. Negative means unused.
  task automatic applyStimulus(input logic [7:0] data, input bit msbOrder,
                               input bit withParity, input bit parityBit,
                               input bit stopBit, input int readyAt,
                               input int resetAt);
    logic frame [0:10];
    int   nBits;
    bit   aborted;
    rxd = 1'b1;
    repeat (4) @(negedge clock);
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[1+i] = msbOrder ? data[7-i] : data[i];
    if (withParity) begin
      frame[9]  = parityBit;
      frame[10] = stopBit;
      nBits     = 11;
    end else begin
      frame[9]  = stopBit;
      frame[10] = 1'b1;
      nBits     = 10;
    end
    aborted = 1'b0;
    for (int idx = 0; idx < nBits * CLKS_PER_BIT; idx++) begin
      if (resetAt >= 0 && idx == resetAt) begin
        resetN  = 1'b0;
        aborted = 1'b1;
      end
      if (resetAt >= 0 && idx == resetAt + 1) resetN = 1'b1;
      if (readyAt >= 0 && idx == readyAt) rxReady = 1'b1;
      if (readyAt >= 0 && idx == readyAt + 1) rxReady = 1'b0;
      rxd = aborted ? 1'b1 : frame[idx / CLKS_PER_BIT];
      @(negedge clock);
    end
    rxd = 1'b1;
  endtask

  task automatic acceptChar();
    rxReady = 1'b1;
    @(negedge clock);
    rxReady = 1'b0;
  endtask

  initial begin
    resetN    = 1'b0;
    rxd       = 1'b1;
    baudDiv   = 16'd3;
    parityEn  = 1'b0;
    parityOdd = 1'b0;
    msbFirst  = 1'b0;
    rxReady   = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("reset_data", rxData, 8'h00);
    checkOutput("reset_valid", rxValid, 8'd0);
    checkOutput("reset_parity_err", parityErr, 8'd0);
    checkOutput("reset_frame_err", frameErr, 8'd0);
    checkOutput("reset_overrun", overrun, 8'd0);
    checkOutput("reset_busy", busy, 8'd0);
    resetN = 1'b1;
    repeat (4) @(negedge clock);

    // Basic LSB-first receive, held until accepted.
    applyStimulus(8'h88, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("basic_valid", rxValid, 8'd1);
    checkOutput("basic_data", rxData, 8'h88);
    checkOutput("basic_parity_err", parityErr, 8'd0);
    checkOutput("basic_frame_err", frameErr, 8'd0);
    checkOutput("basic_busy", busy, 8'd0);
    repeat (20) @(negedge clock);
    checkOutput("basic_hold_valid", rxValid, 8'd1);
    checkOutput("basic_hold_data", rxData, 8'h88);
    acceptChar();
    checkOutput("basic_cleared", rxValid, 8'd0);

    // MSB-first with even parity, then a wrong parity bit, then odd parity.
    parityEn  = 1'b1;
    parityOdd = 1'b0;
    msbFirst  = 1'b1;
    applyStimulus(8'h8C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
    checkOutput("par_even_data", rxData, 8'h8C);
    checkOutput("par_even_ok", parityErr, 8'd0);
    checkOutput("par_even_frame", frameErr, 8'd0);
    acceptChar();
    applyStimulus(8'h8C, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
    checkOutput("par_bad_valid", rxValid, 8'd1);
    checkOutput("par_bad_data", rxData, 8'h8C);
    checkOutput("par_bad_err", parityErr, 8'd1);
    acceptChar();
    parityOdd = 1'b1;
    applyStimulus(8'h8C, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
    checkOutput("par_odd_data", rxData, 8'h8C);
    checkOutput("par_odd_ok", parityErr, 8'd0);
    acceptChar();
    parityEn  = 1'b0;
    parityOdd = 1'b0;
    msbFirst  = 1'b0;

    // Start-bit glitch of 16 clocks must be rejected.
    baseRise = validRiseCount;
    rxd = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("glitch_busy", busy, 8'd1);
    repeat (6) @(negedge clock);
    rxd = 1'b1;
    repeat (44) @(negedge clock);
    checkOutput("glitch_idle", busy, 8'd0);
    checkOutput("glitch_no_valid", rxValid, 8'd0);
    checkOutput("glitch_no_char", validRiseCount - baseRise, 8'd0);
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("after_glitch_data", rxData, 8'h55);
    checkOutput("after_glitch_frame", frameErr, 8'd0);
    acceptChar();

    // Break of more than 20 bit times: one 00 character with a frame error.
    baseRise = validRiseCount;
    rxd = 1'b0;
    repeat (700) @(negedge clock);
    checkOutput("break_valid", rxValid, 8'd1);
    checkOutput("break_data", rxData, 8'h00);
    checkOutput("break_frame_err", frameErr, 8'd1);
    checkOutput("break_parity_err", parityErr, 8'd0);
    acceptChar();
    repeat (580) @(negedge clock);
    checkOutput("break_no_more", rxValid, 8'd0);
    checkOutput("break_wait_high", busy, 8'd1);
    rxd = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("break_released", busy, 8'd0);
    checkOutput("break_one_char", validRiseCount - baseRise, 8'd1);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("after_break_data", rxData, 8'hA5);
    checkOutput("after_break_frame", frameErr, 8'd0);
    acceptChar();

    // Overrun with ready low, then accept on the completion cycle.
    baseOverrun = overrunCount;
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("ovr_first_data", rxData, 8'h11);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("ovr_held_valid", rxValid, 8'd1);
    checkOutput("ovr_held_data", rxData, 8'h11);
    checkOutput("ovr_pulse_count", overrunCount - baseOverrun, 8'd1);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 610, -1);
    checkOutput("simul_valid", rxValid, 8'd1);
    checkOutput("simul_data", rxData, 8'h22);
    checkOutput("simul_no_overrun", overrunCount - baseOverrun, 8'd1);
    acceptChar();

    // Reset during a data bit abandons the frame.
    baseRise = validRiseCount;
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 202);
    checkOutput("rst_data", rxData, 8'h00);
    checkOutput("rst_valid", rxValid, 8'd0);
    checkOutput("rst_busy", busy, 8'd0);
    checkOutput("rst_frame_err", frameErr, 8'd0);
    checkOutput("rst_no_char", validRiseCount - baseRise, 8'd0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    checkOutput("after_rst_valid", rxValid, 8'd1);
    checkOutput("after_rst_data", rxData, 8'h3C);
    acceptChar();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
